// File: rtl/nibble_serial_sub.sv
// Nibble-serial subtractor: diff = in1 - in2 - bin, one 4-bit slice per clock, LSB first.
// Optional NIBBLE_SUB_ADD_MODE_EN adds an 'op' input selecting add (1) or subtract (0).
module nibble_serial_sub #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             bin,
`ifdef NIBBLE_SUB_ADD_MODE_EN
    input  logic             op,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int unsigned K  = WIDTH / 4;
    localparam int unsigned IW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             brw_q, brw_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             add_q, add_d;
    logic [WIDTH-1:0] diff_d;
    logic             bout_d, ovf_d, busy_d, done_d;
    logic [3:0]       a_nib, b_nib;
    logic [4:0]       slice;
    logic             add_sel;

`ifdef NIBBLE_SUB_ADD_MODE_EN
    assign add_sel = op;
`else
    assign add_sel = 1'b0;
`endif

    // State register plus all output and datapath flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            brw_q   <= 1'b0;
            idx_q   <= '0;
            add_q   <= 1'b0;
            diff    <= '0;
            bout    <= 1'b0;
            ovf     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            brw_q   <= brw_d;
            idx_q   <= idx_d;
            add_q   <= add_d;
            diff    <= diff_d;
            bout    <= bout_d;
            ovf     <= ovf_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Next-state, slice arithmetic and next output values
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        brw_d   = brw_q;
        idx_d   = idx_q;
        add_d   = add_q;
        diff_d  = diff;
        bout_d  = bout;
        ovf_d   = ovf;

        a_nib = a_q[{idx_q, 2'b00} +: 4];
        b_nib = b_q[{idx_q, 2'b00} +: 4];
        if (add_q) begin
            slice = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, brw_q};
        end else begin
            slice = {1'b0, a_nib} - {1'b0, b_nib} - {4'b0000, brw_q};
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = in1;
                    b_d     = in2;
                    brw_d   = bin;
                    add_d   = add_sel;
                    idx_d   = '0;
                    diff_d  = '0;
                    bout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                diff_d[{idx_q, 2'b00} +: 4] = slice[3:0];
                brw_d = slice[4];
                idx_d = idx_q + IW'(1);
                if (idx_q == IW'(K - 1)) begin
                    bout_d = slice[4];
                    if (add_q) begin
                        ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice[3] != a_q[WIDTH-1]);
                    end else begin
                        ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (slice[3] != a_q[WIDTH-1]);
                    end
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Scoreboard bench for nibble_serial_sub (WIDTH=16); add-mode cases run when NIBBLE_SUB_ADD_MODE_EN is defined.
module tb_nibble_serial_sub;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned K     = WIDTH / 4;

    typedef struct {
        logic [15:0] diff;
        logic        bout;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] in1 = '0, in2 = '0;
    logic        bin = 1'b0;
    logic        op_r = 1'b0;
    logic        busy, done, bout, ovf;
    logic [15:0] diff;

    int errors = 0;
    int checks = 0;
    exp_t exp_q[$];

    nibble_serial_sub #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .in1   (in1),
        .in2   (in2),
        .bin   (bin),
`ifdef NIBBLE_SUB_ADD_MODE_EN
        .op    (op_r),
`endif
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic, unsigned for borrow/carry, signed for overflow
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic bi, input logic o);
        exp_t r;
        int ua, ub, sa, sb, u, s;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (o) begin
            u = ua + ub + int'(bi);
            s = sa + sb + int'(bi);
            r.bout = (u > 65535);
        end else begin
            u = ua - ub - int'(bi);
            s = sa - sb - int'(bi);
            r.bout = (ua < ub + int'(bi));
        end
        r.diff = 16'(u);
        r.ovf  = (s > 32767) || (s < -32768);
        return r;
    endfunction

    // Called at a negedge; holds start for one cycle and returns at the following negedge
    task automatic pulse(input logic [15:0] a, input logic [15:0] b, input logic bi,
                         input logic o, input bit accept);
        in1 = a; in2 = b; bin = bi; op_r = o; start = 1'b1;
        if (accept) exp_q.push_back(model(a, b, bi, o));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 50);
        if (!done) chk("done_timeout", 32'(n), 32'(K));
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bi, input logic o);
        int n;
        pulse(a, b, bi, o, 1'b1);
        wait_done(n);
        chk("latency", 32'(n), 32'(K));
    endtask

    // Monitor: pops the scoreboard on every done pulse
    int busy_cnt = 0;
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_cnt  = 0;
            prev_done = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                chk("done_width", 32'(prev_done), 32'd0);
                chk("busy_cycles", 32'(busy_cnt), 32'(K));
                busy_cnt = 0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("diff", 32'(diff), 32'(e.diff));
                    chk("bout", 32'(bout), 32'(e.bout));
                    chk("ovf", 32'(ovf), 32'(e.ovf));
                end
            end
            prev_done = done;
        end
    end

    initial begin
        int n;
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_flags", 32'({bout, ovf}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(16'h0005, 16'h0006, 1'b0, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b0, 1'b0);
        run_op(16'h000D, 16'h0002, 1'b1, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b1, 1'b0);
        @(negedge clk);
        chk("idle_after_done", 32'({busy, done}), 32'd0);

        // Start during RUN is ignored; start during DONE is accepted
        pulse(16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        pulse(16'hAAAA, 16'h5555, 1'b1, 1'b0, 1'b0);
        wait_done(n);
        pulse(16'h4321, 16'h8765, 1'b1, 1'b0, 1'b1);
        chk("b2b_busy", 32'(busy), 32'd1);
        wait_done(n);
        chk("b2b_latency", 32'(n), 32'(K));

        // Reset mid-RUN aborts everything
        @(negedge clk);
        pulse(16'hFEDC, 16'h0123, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_diff", 32'(diff), 32'd0);
        chk("midrst_flags", 32'({done, bout, ovf}), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(16'h9ABC, 16'h1234, 1'b1, 1'b0);

`ifdef NIBBLE_SUB_ADD_MODE_EN
        run_op(16'h000F, 16'h000F, 1'b1, 1'b1);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b1);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b1);
`endif

        for (int i = 0; i < 40; i++) begin
            logic o;
`ifdef NIBBLE_SUB_ADD_MODE_EN
            o = 1'($urandom_range(0, 1));
`else
            o = 1'b0;
`endif
            run_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), o);
            if ($urandom_range(0, 2) == 0) @(negedge clk);
        end

        @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
